lab2_sweep_eval: RTL

LAB2_SWEEP_EVAL -- requirements
Module: lab2_sweep_eval

---
 rtl/lab_pkg.sv | 29 ++
 rtl/lab_tt_ram.sv | 44 ++++
 rtl/lab2_sweep_eval.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// ============================================================================
// Module      : lab_pkg
// Description : Shared state encoding and default constants for the
//               truth-table sweep evaluator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lab_pkg;

  // Default hold time per input vector, in clock cycles
  localparam int STEP_CYCLES_DEF = 20;

  // Default signature width
  localparam int SIG_W_DEF = 16;

  // Hold counter width; covers the full legal STEP_CYCLES range up to 255
  localparam int CNT_W = 8;

  // Evaluator controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lab_tt_ram.sv
// ============================================================================
// Module      : lab_tt_ram
// Description : Truth-table storage. Synchronous write, asynchronous read,
//               every entry cleared to zero by reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lab_tt_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Table write port; reset wipes the whole table so a fresh run sees all zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so the evaluator can register lut[x] in the same cycle
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/lab2_sweep_eval.sv
// ============================================================================
// Module      : lab2_sweep_eval
// Description : Applies input vectors to a programmable truth table, either
//               one vector or an exhaustive 0..2**N_IN-1 sweep, holds each
//               vector for STEP_CYCLES cycles and folds the settled outputs
//               into a rotate-XOR signature.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lab2_sweep_eval
  import lab_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int SIG_W       = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tt_we,
  input  logic [N_IN-1:0]  tt_addr,
  input  logic [N_OUT-1:0] tt_wdata,
  input  logic             start,
  input  logic             mode_single,
  input  logic [N_IN-1:0]  vec_in,
  input  logic             abort,
  output logic [N_IN-1:0]  x,
  output logic [N_OUT-1:0] z,
  output logic             z_valid,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               single_q;
  logic               last_step;
  logic               last_vec;
  logic               tt_wr_en;
  logic [N_OUT-1:0]   tt_rdata;

  // The table is frozen while a run is in progress
  assign tt_wr_en  = tt_we && (state != S_RUN);

  // Final hold cycle of the vector currently on x
  assign last_step = (state == S_RUN) && (cnt == CNT_LAST);

  // A single-vector run ends after its one vector; a sweep ends at all-ones
  assign last_vec  = single_q || (&x);

  lab_tt_ram #(
    .ADDR_W (N_IN),
    .DATA_W (N_OUT)
  ) u_tt_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (tt_wr_en),
    .waddr  (tt_addr),
    .wdata  (tt_wdata),
    .raddr  (x),
    .rdata  (tt_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE, abort only counts in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (last_step && last_vec) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state and the hold counter
  always_comb begin
    busy    = (state == S_RUN);
    done    = (state == S_DONE);
    z_valid = last_step;
  end

  // Vector, output, hold-counter and signature datapath; everything holds
  // outside RUN and on the abort cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      z        <= '0;
      sig      <= '0;
      cnt      <= '0;
      single_q <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      x        <= mode_single ? vec_in : '0;
      single_q <= mode_single;
      cnt      <= '0;
      sig      <= '0;
    end else if ((state == S_RUN) && !abort) begin
      z <= tt_rdata;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(z);
        if (!last_vec) begin
          x <= x + N_IN'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
